// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP states, IR opcodes, IDCODE/DTMCS values and DMI layout shared by the debug transport.
package jtag_pkg;
    localparam int IR_W     = 5;
    localparam int ABITS    = 7;
    localparam int DATA_W   = 32;
    localparam int DMI_W    = ABITS + DATA_W + 2;
    localparam int RF_DEPTH = 16;
    localparam int RF_AW    = 4;

    localparam logic [IR_W-1:0] IR_IDCODE  = 5'h01;
    localparam logic [IR_W-1:0] IR_DTMCS   = 5'h10;
    localparam logic [IR_W-1:0] IR_DMI     = 5'h11;
    localparam logic [IR_W-1:0] IR_BYPASS  = 5'h1F;
    localparam logic [IR_W-1:0] IR_CAPTURE = 5'b00001;

    localparam logic [31:0] IDCODE_VAL = 32'h10E31913;
    localparam logic [31:0] DTMCS_VAL  = {22'd0, 6'(ABITS), 4'd1};

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {DMI_NOP, DMI_READ, DMI_WRITE, DMI_RSVD} dmi_op_e;

    function automatic tap_state_e tap_next(tap_state_e s, logic tms);
        tap_state_e n;
        n = TLR;
        case (s)
            TLR:      n = tms ? TLR      : RTI;
            RTI:      n = tms ? SEL_DR   : RTI;
            SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   n = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: n = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: n = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: n = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: n = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   n = tms ? SEL_DR   : RTI;
            SEL_IR:   n = tms ? TLR      : CAP_IR;
            CAP_IR:   n = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: n = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: n = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: n = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: n = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   n = tms ? SEL_DR   : RTI;
        endcase
        return n;
    endfunction
endpackage

// File: rtl/jtag_if.sv
// jtag_if: JTAG pin bundle; master drives TCK/TMS/TDI/TRST, slave returns TDO/DRV_TDO.
interface jtag_if;
    logic TCK;
    logic TMS;
    logic TDI;
    logic TRST;
    logic TDO;
    logic DRV_TDO;

    modport master (output TCK, TMS, TDI, TRST, input TDO, DRV_TDO);
    modport slave  (input TCK, TMS, TDI, TRST, output TDO, DRV_TDO);
endinterface

// File: rtl/jtag_tap.sv
// jtag_tap: 1149.1 TAP state machine, 5-bit IR and TDO driver, stepped by oversampled TCK edges.
// Macro JTAG_TRST_EN: when defined, synchronized TRST forces Test-Logic-Reset.
module jtag_tap
    import jtag_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            step,
    input  logic            fall,
    input  logic            tms,
    input  logic            tdi,
    input  logic            trst,
    input  logic            dr_lsb,
    output logic            tick,
    output tap_state_e      state,
    output logic [IR_W-1:0] ir,
    output logic            tdo,
    output logic            drv_tdo
);
    tap_state_e      state_nx;
    logic [IR_W-1:0] ir_sr, ir_sr_nx, ir_nx;
    logic            tdo_q, tdo_nx, trst_hit;

`ifdef JTAG_TRST_EN
    assign trst_hit = trst;
`else
    logic unused_trst;
    assign unused_trst = trst;
    assign trst_hit    = 1'b0;
`endif

    // TRST suppresses the TCK step so it always wins over a coincident edge
    assign tick    = step & ~trst_hit;
    assign drv_tdo = (state == SHIFT_IR) || (state == SHIFT_DR);
    assign tdo     = drv_tdo & tdo_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= TLR;
            ir    <= IR_IDCODE;
            ir_sr <= '0;
            tdo_q <= 1'b0;
        end else begin
            state <= state_nx;
            ir    <= ir_nx;
            ir_sr <= ir_sr_nx;
            tdo_q <= tdo_nx;
        end
    end

    always_comb begin
        state_nx = trst_hit ? TLR : tick ? tap_next(state, tms) : state;
        ir_sr_nx = !tick ? ir_sr : state == CAP_IR ? IR_CAPTURE :
                   state == SHIFT_IR ? {tdi, ir_sr[IR_W-1:1]} : ir_sr;
        ir_nx    = state_nx == TLR ? IR_IDCODE : (tick && state == UPD_IR) ? ir_sr : ir;
        tdo_nx   = !fall ? tdo_q : state == SHIFT_IR ? ir_sr[0] :
                   state == SHIFT_DR ? dr_lsb : 1'b0;
    end
endmodule

// File: rtl/e300_arty_dev_kit_system.sv
// e300_arty_dev_kit_system: JTAG debug transport with IDCODE/DTMCS/DMI/BYPASS DRs and a 16x32 DMI register file.
// Macro JTAG_TRST_EN: when defined, io_jtag.TRST resets the TAP (see jtag_tap).
module e300_arty_dev_kit_system
    import jtag_pkg::*;
(
    input  logic clock,
    input  logic reset,
    jtag_if.slave io_jtag
);
    logic [1:0]        tck_s, tms_s, tdi_s, trst_s;
    logic              tck_q, rise, fall, step, tick, tms_l, tdi_l, upd, in_rf;
    logic [DMI_W-1:0]  dr, dr_nx;
    logic [ABITS-1:0]  last_addr, d_addr;
    logic [DATA_W-1:0] last_data, d_data;
    logic [DATA_W-1:0] rf [RF_DEPTH];
    dmi_op_e           d_op;
    tap_state_e        state;
    logic [IR_W-1:0]   ir;

    assign rise   = tck_s[1] & ~tck_q;
    assign fall   = ~tck_s[1] & tck_q;
    assign d_addr = dr[DMI_W-1 -: ABITS];
    assign d_data = dr[DATA_W+1:2];
    assign d_op   = dmi_op_e'(dr[1:0]);
    assign in_rf  = d_addr < ABITS'(RF_DEPTH);
    assign upd    = tick && state == UPD_DR && ir == IR_DMI;

    jtag_tap u_tap (
        .clock   (clock),
        .reset   (reset),
        .step    (step),
        .fall    (fall),
        .tms     (tms_l),
        .tdi     (tdi_l),
        .trst    (trst_s[1]),
        .dr_lsb  (dr[0]),
        .tick    (tick),
        .state   (state),
        .ir      (ir),
        .tdo     (io_jtag.TDO),
        .drv_tdo (io_jtag.DRV_TDO)
    );

    // One shared DR; TDI enters at the MSB of whichever length the IR selects
    always_comb begin
        dr_nx = dr;
        if (tick && state == CAP_DR)
            dr_nx = ir == IR_IDCODE ? DMI_W'(IDCODE_VAL) :
                    ir == IR_DTMCS  ? DMI_W'(DTMCS_VAL)  :
                    ir == IR_DMI    ? {last_addr, last_data, DMI_NOP} : '0;
        else if (tick && state == SHIFT_DR)
            dr_nx = ir == IR_DMI ? {tdi_l, dr[DMI_W-1:1]} :
                    (ir == IR_IDCODE || ir == IR_DTMCS) ? DMI_W'({tdi_l, dr[DATA_W-1:1]}) :
                    DMI_W'(tdi_l);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tck_s     <= '0;
            tms_s     <= '0;
            tdi_s     <= '0;
            trst_s    <= '0;
            tck_q     <= 1'b0;
            step      <= 1'b0;
            tms_l     <= 1'b0;
            tdi_l     <= 1'b0;
            dr        <= '0;
            last_addr <= '0;
            last_data <= '0;
            for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
        end else begin
            tck_s  <= {tck_s[0], io_jtag.TCK};
            tms_s  <= {tms_s[0], io_jtag.TMS};
            tdi_s  <= {tdi_s[0], io_jtag.TDI};
            trst_s <= {trst_s[0], io_jtag.TRST};
            tck_q  <= tck_s[1];
            step   <= rise;
            if (rise) begin
                tms_l <= tms_s[1];
                tdi_l <= tdi_s[1];
            end
            dr <= dr_nx;
            if (upd && (d_op == DMI_READ || d_op == DMI_WRITE)) begin
                last_addr <= d_addr;
                last_data <= d_op == DMI_WRITE ? d_data : in_rf ? rf[d_addr[RF_AW-1:0]] : '0;
            end
            if (upd && d_op == DMI_WRITE && in_rf) rf[d_addr[RF_AW-1:0]] <= d_data;
        end
    end
endmodule

// File: tb/tb_e300_arty_dev_kit_system.sv
// tb_e300_arty_dev_kit_system: drives JTAG scans pin-level and checks TDO against a transaction-level DMI model.
module tb_e300_arty_dev_kit_system;
    logic clock = 1'b0;
    logic reset = 1'b0;
    jtag_if io_jtag ();

    e300_arty_dev_kit_system dut (.clock(clock), .reset(reset), .io_jtag(io_jtag));

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int drv_err = 0;
    logic [31:0] mem [16];
    logic [6:0]  m_addr;
    logic [31:0] m_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        m_addr = '0;
        m_data = '0;
    endtask

    // One TCK period of 8 system clocks; TDO/DRV are sampled just before the rising edge
    task automatic go(input logic tms, input logic tdi, input logic exp_drv, output logic tdo);
        io_jtag.TMS = tms;
        io_jtag.TDI = tdi;
        repeat (4) @(negedge clock);
        tdo = io_jtag.TDO;
        if (io_jtag.DRV_TDO !== exp_drv) drv_err++;
        io_jtag.TCK = 1'b1;
        repeat (4) @(negedge clock);
        io_jtag.TCK = 1'b0;
    endtask

    task automatic shift(input logic [63:0] din, input int n, output logic [63:0] dout);
        logic t;
        dout = '0;
        for (int i = 0; i < n; i++) begin
            go(i == n - 1, din[i], 1'b1, t);
            dout[i] = t;
        end
    endtask

    task automatic scan_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
        logic t;
        drv_err = 0;
        go(1, 0, 0, t); go(0, 0, 0, t); go(0, 0, 0, t);
        shift(din, n, dout);
        go(1, 0, 0, t); go(0, 0, 0, t);
    endtask

    task automatic scan_ir(input logic [4:0] op, output logic [63:0] dout);
        logic t;
        drv_err = 0;
        go(1, 0, 0, t); go(1, 0, 0, t); go(0, 0, 0, t); go(0, 0, 0, t);
        shift(64'(op), 5, dout);
        go(1, 0, 0, t); go(0, 0, 0, t);
    endtask

    task automatic dmi(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                       input string tag, output logic [63:0] dout);
        scan_dr(64'({addr, data, op}), 41, dout);
        check(tag, dout, 64'({m_addr, m_data, 2'b00}));
        check({tag, "_drv"}, 64'(drv_err), 64'd0);
        if (op == 2'd1) begin
            m_addr = addr;
            m_data = addr < 7'd16 ? mem[addr[3:0]] : 32'd0;
        end else if (op == 2'd2) begin
            m_addr = addr;
            m_data = data;
            if (addr < 7'd16) mem[addr[3:0]] = data;
        end
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [15:0] pat;
        logic [4:0]  op;
        logic        t;
        io_jtag.TCK = 0; io_jtag.TMS = 1; io_jtag.TDI = 0; io_jtag.TRST = 0;
        model_reset();
        repeat (5) @(negedge clock);
        check("rst_tdo", 64'(io_jtag.TDO), 64'd0);
        check("rst_drv", 64'(io_jtag.DRV_TDO), 64'd0);
        reset = 1'b1;

        drv_err = 0;
        repeat (5) go(1, 0, 0, t);
        go(0, 0, 0, t);
        check("tlr_walk_drv", 64'(drv_err), 64'd0);

        scan_dr(64'd0, 32, d);
        check("idcode", d, 64'h10E31913);
        check("idcode_drv", 64'(drv_err), 64'd0);

        scan_ir(5'h1F, d);
        check("ir_capture", d, 64'd1);
        check("ir_drv", 64'(drv_err), 64'd0);
        scan_dr(64'b1011, 4, d);
        check("bypass_1011", d, 64'b0110);

        // Unassigned opcodes must behave as the 1-bit bypass
        for (int k = 0; k < 3; k++) begin
            do op = 5'($urandom_range(0, 31)); while (op == 5'h01 || op == 5'h10 || op == 5'h11);
            scan_ir(op, d);
            pat = 16'($urandom);
            scan_dr(64'(pat), 16, d);
            check($sformatf("bypass_op%0h", op), d, 64'({pat[14:0], 1'b0}));
        end

        scan_ir(5'h10, d);
        scan_dr(64'($urandom), 32, d);
        check("dtmcs", d, 64'h71);
        scan_dr(64'd0, 32, d);
        check("dtmcs_ro", d, 64'h71);

        scan_ir(5'h11, d);
        dmi(2'd2, 7'd3, 32'hDEADBEEF, "dmi_wr3", d);
        dmi(2'd1, 7'd3, 32'd0, "dmi_rd3", d);
        dmi(2'd0, 7'd0, 32'd0, "dmi_nop3", d);
        check("dmi_rd3_data", 64'(d[33:2]), 64'hDEADBEEF);
        check("dmi_rd3_op", 64'(d[1:0]), 64'd0);
        dmi(2'd1, 7'h20, 32'd0, "dmi_rd20", d);
        dmi(2'd0, 7'd0, 32'd0, "dmi_nop20", d);
        check("dmi_rd20_data", 64'(d[33:2]), 64'd0);

        for (int k = 0; k < 24; k++)
            dmi(2'($urandom_range(0, 3)), 7'($urandom_range(0, 19)), $urandom, $sformatf("dmi_rand%0d", k), d);

        // TRST pulse while sitting in Shift-DR with BYPASS selected
        scan_ir(5'h1F, d);
        drv_err = 0;
        go(1, 0, 0, t); go(0, 0, 0, t); go(0, 0, 0, t);
        repeat (4) @(negedge clock);
        check("pre_trst_drv", 64'(io_jtag.DRV_TDO), 64'd1);
        io_jtag.TRST = 1'b1;
        repeat (3) @(negedge clock);
`ifdef JTAG_TRST_EN
        check("trst_drv", 64'(io_jtag.DRV_TDO), 64'd0);
        io_jtag.TRST = 1'b0;
        repeat (4) @(negedge clock);
        go(0, 0, 0, t);
        scan_dr(64'd0, 32, d);
        check("trst_idcode", d, 64'h10E31913);
`else
        check("trst_ignored_drv", 64'(io_jtag.DRV_TDO), 64'd1);
        io_jtag.TRST = 1'b0;
        repeat (4) @(negedge clock);
        pat = 16'($urandom);
        shift(64'(pat[7:0]), 8, d);
        go(1, 0, 0, t); go(0, 0, 0, t);
        check("trst_ignored_bypass", d, 64'({pat[6:0], 1'b0}));
        check("trst_ignored_drverr", 64'(drv_err), 64'd0);
`endif

        // Reset in the middle of a DMI write scan
        scan_ir(5'h11, d);
        go(1, 0, 0, t); go(0, 0, 0, t); go(0, 0, 0, t);
        d = 64'({7'd5, 32'hCAFEF00D, 2'd2});
        for (int i = 0; i < 20; i++) go(0, d[i], 1'b1, t);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("midscan_rst_drv", 64'(io_jtag.DRV_TDO), 64'd0);
        reset = 1'b1;
        model_reset();
        go(0, 0, 0, t);
        scan_dr(64'd0, 32, d);
        check("post_rst_idcode", d, 64'h10E31913);
        scan_ir(5'h11, d);
        dmi(2'd1, 7'd5, 32'd0, "post_rst_rd5", d);
        dmi(2'd1, 7'd3, 32'd0, "post_rst_rd3", d);
        dmi(2'd0, 7'd0, 32'd0, "post_rst_nop", d);
        check("post_rst_rf3", 64'(d[33:2]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
